// File: rtl/router_pkg.sv
// Shared definitions for the router packet register: status FSM encoding,
// check-mode selectors and default geometry.
package router_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int CHK_XOR = 0;
  localparam int CHK_SUM = 1;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 2;
  localparam int DEF_NUM_PORTS = 3;

endpackage

// File: rtl/router_pkt_reg_if.sv
// Controller/FIFO side bundle of the packet register: state strobes and byte in,
// registered byte and per-packet status out.
interface router_pkt_reg_if #(
  parameter int DATA_W = router_pkg::DEF_DATA_W
);

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic [DATA_W-1:0] dout;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;
  logic              len_err;

  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_pkt_valid, err, len_err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_pkt_valid, err, len_err
  );

endinterface

// File: rtl/router_chk_acc.sv
// Running packet check value: XOR parity or additive checksum mod 2^DATA_W.
// Clear beats load beats accumulate; result is registered, one edge of latency.
module router_chk_acc
  import router_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CHK_MODE = CHK_XOR
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_dat,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_dat,
  output logic [DATA_W-1:0] o_acc
);

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_fold;

  always_comb begin
    if (CHK_MODE == CHK_SUM) w_fold = r_acc + i_dat;
    else                     w_fold = r_acc ^ i_dat;
  end

  // Loading from zero is the identity for both fold functions.
  always_ff @(posedge clock) begin
    if (!resetn)     r_acc <= '0;
    else if (i_clr)  r_acc <= '0;
    else if (i_load) r_acc <= i_load_dat;
    else if (i_en)   r_acc <= w_fold;
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/router_pkt_reg.sv
// Router packet register: captures header, forwards bytes to the FIFO with a one-byte
// hold under fifo_full, accumulates the check value and flags err/len_err a cycle after parity_done.
module router_pkt_reg
  import router_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int CHK_MODE  = CHK_XOR
) (
  input logic             clock,
  input logic             resetn,
  router_pkt_reg_if.slave io_bus
);

  localparam int LEN_W = DATA_W - ADDR_W;

  logic [ADDR_W-1:0] w_addr;
  logic              w_hdr_cap;
  logic              w_acc_en;
  logic              w_pd_set;
  logic              w_pd_rise;
  logic              w_eval;
  logic [DATA_W-1:0] w_int_chk;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_hdr_q;
  logic [DATA_W-1:0] r_hold_q;
  logic [DATA_W-1:0] r_pkt_chk;
  logic [LEN_W-1:0]  r_pay_cnt;
  logic              r_parity_done;
  logic              r_low_pkt_valid;
  logic              r_err;
  logic              r_len_err;
  state_t            r_state;

  assign w_addr    = io_bus.data_in[ADDR_W-1:0];
  assign w_hdr_cap = io_bus.detect_add & io_bus.pkt_valid & (int'(w_addr) < NUM_PORTS);
  assign w_acc_en  = io_bus.ld_state & io_bus.pkt_valid & ~io_bus.full_state;
  assign w_pd_set  = (io_bus.ld_state & ~io_bus.fifo_full & ~io_bus.pkt_valid) |
                     (io_bus.laf_state & r_low_pkt_valid & ~r_parity_done);
  assign w_pd_rise = w_pd_set & ~io_bus.detect_add & ~r_parity_done;

  router_chk_acc #(
    .DATA_W   (DATA_W),
    .CHK_MODE (CHK_MODE)
  ) u_chk_acc (
    .clock      (clock),
    .resetn     (resetn),
    .i_clr      (io_bus.detect_add),
    .i_load     (io_bus.lfd_state),
    .i_load_dat (r_hdr_q),
    .i_en       (w_acc_en),
    .i_dat      (io_bus.data_in),
    .o_acc      (w_int_chk)
  );

  always_ff @(posedge clock) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // A valid header restarts the packet from any state.
  always_comb begin
    w_state_nxt = r_state;
    w_eval      = 1'b0;
    unique case (r_state)
      S_IDLE:  w_state_nxt = S_IDLE;
      S_BUSY:  if (w_pd_rise) w_state_nxt = S_CHECK;
      S_CHECK: begin
        w_eval      = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE:  if (io_bus.rst_int_reg) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_hdr_cap) w_state_nxt = S_BUSY;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_dout          <= '0;
      r_hdr_q         <= '0;
      r_hold_q        <= '0;
      r_pkt_chk       <= '0;
      r_pay_cnt       <= '0;
      r_parity_done   <= 1'b0;
      r_low_pkt_valid <= 1'b0;
      r_err           <= 1'b0;
      r_len_err       <= 1'b0;
    end else begin
      if (w_hdr_cap) r_hdr_q <= io_bus.data_in;

      if (io_bus.lfd_state)                          r_dout <= r_hdr_q;
      else if (io_bus.ld_state && !io_bus.fifo_full) r_dout <= io_bus.data_in;
      else if (io_bus.laf_state)                     r_dout <= r_hold_q;

      if (io_bus.ld_state && io_bus.fifo_full) r_hold_q <= io_bus.data_in;

      if (io_bus.detect_add)                     r_pay_cnt <= '0;
      else if (w_acc_en && (r_pay_cnt != '1))    r_pay_cnt <= r_pay_cnt + LEN_W'(1);

      if (io_bus.ld_state && !io_bus.pkt_valid) r_pkt_chk <= io_bus.data_in;

      if (io_bus.rst_int_reg)                        r_low_pkt_valid <= 1'b0;
      else if (io_bus.ld_state && !io_bus.pkt_valid) r_low_pkt_valid <= 1'b1;

      if (io_bus.detect_add) r_parity_done <= 1'b0;
      else if (w_pd_set)     r_parity_done <= 1'b1;

      if (w_hdr_cap) begin
        r_err     <= 1'b0;
        r_len_err <= 1'b0;
      end else if (w_eval) begin
        r_err     <= (w_int_chk != r_pkt_chk);
        r_len_err <= (r_pay_cnt != r_hdr_q[DATA_W-1:ADDR_W]);
      end
    end
  end

  assign io_bus.dout          = r_dout;
  assign io_bus.parity_done   = r_parity_done;
  assign io_bus.low_pkt_valid = r_low_pkt_valid;
  assign io_bus.err           = r_err;
  assign io_bus.len_err       = r_len_err;

endmodule

// File: tb/tb_router_pkt_reg.sv
// Bench for router_pkt_reg: two DUTs (XOR and checksum mode) share one stimulus stream,
// compared every cycle against a packet-level model plus directed literal expectations.
module tb_router_pkt_reg;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg;
  logic [7:0] data_in;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clock = ~clock;

  router_pkt_reg_if #(.DATA_W(8)) if0 ();
  router_pkt_reg_if #(.DATA_W(8)) if1 ();

  assign if0.pkt_valid   = pkt_valid;   assign if1.pkt_valid   = pkt_valid;
  assign if0.data_in     = data_in;     assign if1.data_in     = data_in;
  assign if0.fifo_full   = fifo_full;   assign if1.fifo_full   = fifo_full;
  assign if0.detect_add  = detect_add;  assign if1.detect_add  = detect_add;
  assign if0.lfd_state   = lfd_state;   assign if1.lfd_state   = lfd_state;
  assign if0.ld_state    = ld_state;    assign if1.ld_state    = ld_state;
  assign if0.laf_state   = laf_state;   assign if1.laf_state   = laf_state;
  assign if0.full_state  = full_state;  assign if1.full_state  = full_state;
  assign if0.rst_int_reg = rst_int_reg; assign if1.rst_int_reg = rst_int_reg;

  router_pkt_reg #(.DATA_W(8), .ADDR_W(2), .NUM_PORTS(3), .CHK_MODE(0)) dut0 (
    .clock (clock), .resetn (resetn), .io_bus (if0.slave));
  router_pkt_reg #(.DATA_W(8), .ADDR_W(2), .NUM_PORTS(3), .CHK_MODE(1)) dut1 (
    .clock (clock), .resetn (resetn), .io_bus (if1.slave));

  function automatic void cmp8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void cmp1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endfunction

  // Check value of a byte list: mode 0 XOR, mode 1 sum mod 256.
  function automatic logic [7:0] fold(input logic [7:0] q[$], input int mode);
    logic [7:0] a;
    a = 8'h00;
    foreach (q[i]) a = (mode == 1) ? (a + q[i]) : (a ^ q[i]);
    return a;
  endfunction

  // ---------------- reference model ----------------
  bit         m_live = 1'b0;
  logic [7:0] m_dout, m_hdr, m_hold, m_pkt_chk;
  logic [7:0] m_bytes[$];
  int         m_cnt;
  bit         m_low, m_pd, m_err0, m_err1, m_len_err;
  int         m_phase;  // 0 no packet, 1 collecting, 2 verdict due, 3 verdict shown

  always @(posedge clock) begin
    bit cap, pd_set;
    if (!resetn) begin
      m_live = 1'b1;
      m_dout = 8'h00; m_hdr = 8'h00; m_hold = 8'h00; m_pkt_chk = 8'h00;
      m_bytes.delete(); m_cnt = 0;
      m_low = 0; m_pd = 0; m_err0 = 0; m_err1 = 0; m_len_err = 0; m_phase = 0;
    end else begin
      cap    = detect_add && pkt_valid && (int'(data_in[1:0]) < 3);
      pd_set = (ld_state && !fifo_full && !pkt_valid) || (laf_state && m_low && !m_pd);
      if (cap) begin
        m_err0 = 0; m_err1 = 0; m_len_err = 0;
      end else if (m_phase == 2) begin
        m_err0    = (fold(m_bytes, 0) != m_pkt_chk);
        m_err1    = (fold(m_bytes, 1) != m_pkt_chk);
        m_len_err = (m_cnt != int'(m_hdr >> 2));
      end
      if (cap) m_phase = 1;
      else if (m_phase == 1 && pd_set && !detect_add && !m_pd) m_phase = 2;
      else if (m_phase == 2) m_phase = 3;
      else if (m_phase == 3 && rst_int_reg) m_phase = 0;

      if (lfd_state)                    m_dout = m_hdr;
      else if (ld_state && !fifo_full)  m_dout = data_in;
      else if (laf_state)               m_dout = m_hold;
      if (ld_state && fifo_full) m_hold = data_in;

      if (detect_add) begin
        m_bytes.delete(); m_cnt = 0;
      end else if (lfd_state) begin
        m_bytes.delete(); m_bytes.push_back(m_hdr);
      end else if (ld_state && pkt_valid && !full_state) begin
        m_bytes.push_back(data_in);
        if (m_cnt < 63) m_cnt++;
      end
      if (cap) m_hdr = data_in;
      if (ld_state && !pkt_valid) m_pkt_chk = data_in;
      if (rst_int_reg) m_low = 0;
      else if (ld_state && !pkt_valid) m_low = 1;
      if (detect_add) m_pd = 0;
      else if (pd_set) m_pd = 1;
    end
  end

  always @(negedge clock) begin
    if (m_live) begin
      cmp8("dout0", if0.dout, m_dout);
      cmp8("dout1", if1.dout, m_dout);
      cmp1("parity_done0", if0.parity_done, m_pd);
      cmp1("parity_done1", if1.parity_done, m_pd);
      cmp1("low_pkt_valid0", if0.low_pkt_valid, m_low);
      cmp1("low_pkt_valid1", if1.low_pkt_valid, m_low);
      cmp1("err_xor", if0.err, m_err0);
      cmp1("err_sum", if1.err, m_err1);
      cmp1("len_err0", if0.len_err, m_len_err);
      cmp1("len_err1", if1.len_err, m_len_err);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] douts[$];
  logic       v_pd, v_err0, v_err1, v_len;

  task automatic step(input logic da, lfd, ld, laf, fs, ri, pv, ff, input logic [7:0] d);
    detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
    full_state = fs; rst_int_reg = ri; pkt_valid = pv; fifo_full = ff; data_in = d;
    @(negedge clock);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'($urandom));
  endtask

  task automatic run_pkt(input logic [7:0] hdr, input logic [7:0] pay[$], input logic [7:0] chk,
                         input int stall_at, input bit stall_chk);
    douts.delete();
    step(1, 0, 0, 0, 0, 0, 1, 0, hdr);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'($urandom));
    douts.push_back(if0.dout);
    foreach (pay[i]) begin
      if (i == stall_at) begin
        step(0, 0, 1, 0, 0, 0, 1, 1, pay[i]);
        step(0, 0, 1, 0, 1, 0, 1, 1, pay[i]);
        step(0, 0, 0, 1, 0, 0, 1, 0, 8'($urandom));
      end else begin
        step(0, 0, 1, 0, 0, 0, 1, 0, pay[i]);
      end
      douts.push_back(if0.dout);
    end
    if (stall_chk) begin
      step(0, 0, 1, 0, 0, 0, 0, 1, chk);
      step(0, 0, 0, 1, 0, 0, 0, 0, 8'($urandom));
    end else begin
      step(0, 0, 1, 0, 0, 0, 0, 0, chk);
    end
    v_pd = if0.parity_done;
    idle();
    v_err0 = if0.err; v_err1 = if1.err; v_len = if0.len_err;
    idle();
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    idle();
  endtask

  initial begin
    logic [7:0] pay3[$];
    logic [7:0] pay2[$];
    logic [7:0] seq[$];
    logic [7:0] rp[$];
    logic [7:0] tq[$];
    logic [7:0] hdr, ck;
    int         len, n, stall;

    resetn = 1'b0;
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    full_state = 0; rst_int_reg = 0; pkt_valid = 0; fifo_full = 0; data_in = 8'h00;
    @(negedge clock);
    @(negedge clock);
    cmp8("rst_dout", if0.dout, 8'h00);
    cmp1("rst_parity_done", if0.parity_done, 1'b0);
    cmp1("rst_low", if0.low_pkt_valid, 1'b0);
    cmp1("rst_err", if0.err, 1'b0);
    cmp1("rst_len_err", if1.len_err, 1'b0);
    resetn = 1'b1;

    pay3 = '{8'h11, 8'h22, 8'h33};
    pay2 = '{8'h11, 8'h22};
    seq  = '{8'h0E, 8'h11, 8'h22, 8'h33};
    cmp8("model_xor", fold(seq, 0), 8'h0E);
    cmp8("model_sum", fold(seq, 1), 8'h74);

    // good packet, XOR check
    run_pkt(8'h0E, pay3, 8'h0E, -1, 0);
    cmp8("good_nbytes", 8'(douts.size()), 8'd4);
    foreach (seq[i]) cmp8("good_dout_seq", douts[i], seq[i]);
    cmp1("good_pd", v_pd, 1'b1);
    cmp1("good_err", v_err0, 1'b0);
    cmp1("good_len_err", v_len, 1'b0);
    cmp1("good_err_summode", v_err1, 1'b1);

    // bad check byte, then cleared by next header
    run_pkt(8'h0E, pay3, 8'h0F, -1, 0);
    cmp1("bad_err", v_err0, 1'b1);
    cmp1("bad_len_err", v_len, 1'b0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h0E);
    cmp1("bad_err_cleared", if0.err, 1'b0);
    cmp1("bad_err_cleared_sum", if1.err, 1'b0);

    // short packet, correct parity
    run_pkt(8'h0E, pay2, 8'h3D, -1, 0);
    cmp1("short_err", v_err0, 1'b0);
    cmp1("short_len_err", v_len, 1'b1);

    // stall on 0x22, re-presented under full_state, released by laf_state
    run_pkt(8'h0E, pay3, 8'h0E, 1, 0);
    cmp8("stall_laf_dout", douts[2], 8'h22);
    cmp1("stall_err", v_err0, 1'b0);
    cmp1("stall_len_err", v_len, 1'b0);

    // check byte stalled, parity_done set via laf_state
    run_pkt(8'h0E, pay3, 8'h0E, -1, 1);
    cmp1("chkstall_pd", v_pd, 1'b1);
    cmp1("chkstall_err", v_err0, 1'b0);

    // checksum mode good, XOR mode bad
    run_pkt(8'h0E, pay3, 8'h74, -1, 0);
    cmp1("sum_err", v_err1, 1'b0);
    cmp1("sum_err_xormode", v_err0, 1'b1);

    // invalid address: header and status untouched, no verdict
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h0F);
    cmp1("inv_err_kept", if0.err, 1'b1);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
    cmp8("inv_hdr_kept", if0.dout, 8'h0E);
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h55);
    idle();
    idle();
    cmp1("inv_no_verdict_len", if0.len_err, 1'b0);
    cmp1("inv_no_verdict_err", if0.err, 1'b1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);

    // reset mid-packet
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h0E);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h11);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h22);
    cmp8("midrst_pre_dout", if0.dout, 8'h22);
    resetn = 1'b0;
    idle();
    cmp8("midrst_dout", if0.dout, 8'h00);
    cmp1("midrst_pd", if0.parity_done, 1'b0);
    cmp1("midrst_err", if0.err, 1'b0);
    resetn = 1'b1;
    run_pkt(8'h0E, pay3, 8'h0E, -1, 0);
    cmp1("after_rst_err", v_err0, 1'b0);
    cmp1("after_rst_len_err", v_len, 1'b0);

    // randomized packets
    for (int k = 0; k < 300; k++) begin
      len = int'($urandom_range(0, 6));
      n   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : len;
      hdr = 8'(len * 4 + int'($urandom_range(0, 3)));
      rp.delete();
      repeat (n) rp.push_back(8'($urandom));
      tq = rp;
      tq.push_front(hdr);
      ck = ($urandom_range(0, 3) == 0) ? 8'($urandom) : fold(tq, int'($urandom_range(0, 1)));
      stall = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_pkt(hdr, rp, ck, stall, ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
